// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU: opcodes, header size and packet FSM states.
package uart_alu_pkg;

  localparam logic [7:0]  OP_ECHO   = 8'hEC;
  localparam logic [7:0]  OP_ADD    = 8'hA0;
  localparam logic [7:0]  OP_MUL    = 8'hA1;
  // Packet length on the wire counts the header too.
  localparam logic [15:0] HDR_BYTES = 16'd4;

  typedef enum logic [2:0] {
    ST_OPCODE,
    ST_RSVD,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_PAYLOAD,
    ST_RESULT_TX
  } state_e;

endpackage

// File: rtl/uart_alu_uart.sv
// 8N1 UART core with AXI-stream style byte interfaces.
// Bit time is prescale_i*8 clocks. Synchronous active-high reset.
// Ports:
//   clk_i, rst_i                 clock, reset (active-high, synchronous)
//   s_axis_*                     byte to transmit (valid/ready)
//   m_axis_*                     received byte (valid/ready, 1-deep)
//   rxd_i / txd_o                serial lines, idle high
//   rx_frame_error_o             1-cycle pulse: stop bit sampled low
//   rx_overrun_error_o           1-cycle pulse: new byte overwrote an untaken one
//   prescale_i                   clocks per bit / 8
module uart_alu_uart #(
  parameter int DATA_WIDTH_P = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DATA_WIDTH_P-1:0] s_axis_tdata_i,
  input  logic                    s_axis_tvalid_i,
  output logic                    s_axis_tready_o,
  output logic [DATA_WIDTH_P-1:0] m_axis_tdata_o,
  output logic                    m_axis_tvalid_o,
  input  logic                    m_axis_tready_i,
  input  logic                    rxd_i,
  output logic                    txd_o,
  output logic                    rx_frame_error_o,
  output logic                    rx_overrun_error_o,
  input  logic [15:0]             prescale_i
);

  localparam int BW = $clog2(DATA_WIDTH_P + 2);

  logic [18:0] bit_len, half_len;
  assign bit_len  = {prescale_i, 3'b000};
  assign half_len = {1'b0, prescale_i, 2'b00};

  // ---------------- transmitter ----------------
  logic [DATA_WIDTH_P:0]   tx_sh_q;   // {stop, data}, shifted out LSB first
  logic [BW-1:0]           tx_bit_q;
  logic [18:0]             tx_cnt_q;
  logic                    tx_busy_q, txd_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_sh_q   <= '0;
      tx_bit_q  <= '0;
      tx_cnt_q  <= '0;
      tx_busy_q <= 1'b0;
      txd_q     <= 1'b1;
    end else if (!tx_busy_q) begin
      if (s_axis_tvalid_i) begin
        tx_sh_q   <= {1'b1, s_axis_tdata_i};
        txd_q     <= 1'b0;                      // start bit
        tx_bit_q  <= BW'(DATA_WIDTH_P + 1);
        tx_cnt_q  <= bit_len - 19'd1;
        tx_busy_q <= 1'b1;
      end
    end else if (tx_cnt_q != '0) begin
      tx_cnt_q <= tx_cnt_q - 19'd1;
    end else if (tx_bit_q != '0) begin
      txd_q    <= tx_sh_q[0];
      tx_sh_q  <= tx_sh_q >> 1;
      tx_bit_q <= tx_bit_q - 1'b1;
      tx_cnt_q <= bit_len - 19'd1;
    end else begin
      tx_busy_q <= 1'b0;                        // full stop bit elapsed
    end
  end

  assign s_axis_tready_o = !tx_busy_q;
  assign txd_o           = txd_q;

  // ---------------- receiver ----------------
  logic                    rx_s1_q, rx_s2_q, rx_busy_q, rx_vld_q, rx_ferr_q, rx_oerr_q;
  logic [BW-1:0]           rx_bit_q;   // 0 = start check, 1..DW = data, DW+1 = stop
  logic [18:0]             rx_cnt_q;
  logic [DATA_WIDTH_P-1:0] rx_sh_q, rx_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_busy_q <= 1'b0;
      rx_vld_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
      rx_oerr_q <= 1'b0;
      rx_bit_q  <= '0;
      rx_cnt_q  <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
    end else begin
      rx_s1_q   <= rxd_i;
      rx_s2_q   <= rx_s1_q;
      rx_ferr_q <= 1'b0;
      rx_oerr_q <= 1'b0;
      if (rx_vld_q && m_axis_tready_i) rx_vld_q <= 1'b0;
      if (!rx_busy_q) begin
        if (!rx_s2_q) begin
          // Falling edge: next sample lands mid start bit.
          rx_busy_q <= 1'b1;
          rx_bit_q  <= '0;
          rx_cnt_q  <= half_len - 19'd1;
        end
      end else if (rx_cnt_q != '0) begin
        rx_cnt_q <= rx_cnt_q - 19'd1;
      end else begin
        rx_cnt_q <= bit_len - 19'd1;
        rx_bit_q <= rx_bit_q + 1'b1;
        if (rx_bit_q == '0) begin
          if (rx_s2_q) rx_busy_q <= 1'b0;       // glitch, not a start bit
        end else if (rx_bit_q <= BW'(DATA_WIDTH_P)) begin
          rx_sh_q <= {rx_s2_q, rx_sh_q[DATA_WIDTH_P-1:1]};
        end else begin
          rx_busy_q <= 1'b0;
          rx_data_q <= rx_sh_q;
          rx_vld_q  <= 1'b1;
          rx_oerr_q <= rx_vld_q && !m_axis_tready_i;
          rx_ferr_q <= !rx_s2_q;
        end
      end
    end
  end

  assign m_axis_tdata_o     = rx_data_q;
  assign m_axis_tvalid_o    = rx_vld_q;
  assign rx_frame_error_o   = rx_ferr_q;
  assign rx_overrun_error_o = rx_oerr_q;

endmodule

// File: rtl/uart_alu_top.sv
// UART ALU top: parses command packets from rx_i and answers on tx_o.
// Packet: opcode, reserved, len_lo, len_hi, payload (len includes the header).
// ECHO retransmits payload; ADD/MUL fold 32-bit LE operands and send a 4-byte LE result.
// Ports:
//   clk   system clock
//   rst   synchronous active-low reset
//   rx_i  UART serial in (idle high)
//   tx_o  UART serial out (idle high)
module uart_alu_top
  import uart_alu_pkg::*;
#(
  parameter int DATA_WIDTH_P = 8,
  parameter int PRESCALE_P   = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic tx_o
);

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d, len_lo_q, len_lo_d, hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d, have_acc_q, have_acc_d;
  logic [15:0] plen_q, plen_d, cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d, opnd_q, opnd_d;
  logic [1:0]  tx_idx_q, tx_idx_d;

  logic [DATA_WIDTH_P-1:0] rx_data, tx_data;
  logic        rx_vld, rx_rdy, rx_fire, tx_vld, tx_rdy, tx_fire;
  logic        unused_rx_ferr, unused_rx_oerr;
  logic [15:0] len_full;
  logic [31:0] opnd_full;
  logic        is_arith;

  uart_alu_uart #(.DATA_WIDTH_P(DATA_WIDTH_P)) u_uart (
    .clk_i              (clk),
    .rst_i              (~rst),
    .s_axis_tdata_i     (tx_data),
    .s_axis_tvalid_i    (tx_vld),
    .s_axis_tready_o    (tx_rdy),
    .m_axis_tdata_o     (rx_data),
    .m_axis_tvalid_o    (rx_vld),
    .m_axis_tready_i    (rx_rdy),
    .rxd_i              (rx_i),
    .txd_o              (tx_o),
    .rx_frame_error_o   (unused_rx_ferr),
    .rx_overrun_error_o (unused_rx_oerr),
    .prescale_i         (16'(PRESCALE_P))
  );

  // RX stalls while the echo byte waits, so echo never overwrites the holding reg.
  assign rx_rdy    = (state_q != ST_RESULT_TX) && !hold_vld_q;
  assign rx_fire   = rx_vld && rx_rdy;
  assign tx_vld    = (state_q == ST_RESULT_TX) || hold_vld_q;
  assign tx_fire   = tx_vld && tx_rdy;
  assign len_full  = {rx_data, len_lo_q};
  assign opnd_full = {rx_data, opnd_q[31:8]};   // LE bytes shift in from the top
  assign is_arith  = (op_q == OP_ADD) || (op_q == OP_MUL);

  always_comb begin
    tx_data = hold_q;
    if (state_q == ST_RESULT_TX) begin
      case (tx_idx_q)
        2'd0:    tx_data = acc_q[7:0];
        2'd1:    tx_data = acc_q[15:8];
        2'd2:    tx_data = acc_q[23:16];
        default: tx_data = acc_q[31:24];
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_lo_d   = len_lo_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    have_acc_d = have_acc_q;
    plen_d     = plen_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    tx_idx_d   = tx_idx_q;

    if (tx_fire && state_q != ST_RESULT_TX) hold_vld_d = 1'b0;

    case (state_q)
      ST_OPCODE: if (rx_fire) begin
        op_d    = rx_data;
        state_d = ST_RSVD;
      end
      ST_RSVD: if (rx_fire) state_d = ST_LEN_LO;
      ST_LEN_LO: if (rx_fire) begin
        len_lo_d = rx_data;
        state_d  = ST_LEN_HI;
      end
      ST_LEN_HI: if (rx_fire) begin
        cnt_d      = '0;
        have_acc_d = 1'b0;
        acc_d      = '0;
        if (len_full > HDR_BYTES) begin
          plen_d  = len_full - HDR_BYTES;
          state_d = ST_PAYLOAD;
        end else begin
          plen_d  = '0;
          state_d = ST_OPCODE;
        end
      end
      ST_PAYLOAD: if (rx_fire) begin
        cnt_d    = cnt_q + 16'd1;
        opnd_d   = opnd_full;
        tx_idx_d = '0;
        if (op_q == OP_ECHO) begin
          hold_d     = rx_data;
          hold_vld_d = 1'b1;
        end
        // Only complete operands fold in; a trailing partial one never does.
        if (is_arith && cnt_q[1:0] == 2'd3) begin
          have_acc_d = 1'b1;
          if (!have_acc_q)         acc_d = opnd_full;
          else if (op_q == OP_ADD) acc_d = acc_q + opnd_full;
          else                     acc_d = acc_q * opnd_full;
        end
        if (cnt_d == plen_q)
          state_d = (is_arith && have_acc_d) ? ST_RESULT_TX : ST_OPCODE;
      end
      ST_RESULT_TX: if (tx_fire) begin
        tx_idx_d = tx_idx_q + 2'd1;
        if (tx_idx_q == 2'd3) state_d = ST_OPCODE;
      end
      default: state_d = ST_OPCODE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_OPCODE;
      op_q       <= '0;
      len_lo_q   <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      have_acc_q <= 1'b0;
      plen_q     <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      tx_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      len_lo_q   <= len_lo_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      have_acc_q <= have_acc_d;
      plen_q     <= plen_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      tx_idx_q   <= tx_idx_d;
    end
  end

endmodule

// File: tb/tb_uart_alu_top.sv
`timescale 1ns/1ps
module tb_uart_alu_top;

  localparam int PRESCALE  = 2;
  localparam int BIT       = PRESCALE * 8;
  localparam int BYTE_CLKS = BIT * 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_i = 1'b1;
  logic tx_o;

  always #18.018 clk = ~clk;

  uart_alu_top #(.DATA_WIDTH_P(8), .PRESCALE_P(PRESCALE)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx_i (rx_i),
    .tx_o (tx_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  byte unsigned txq[$];    // bytes decoded from tx_o
  byte unsigned exp_q[$];  // reference model output
  byte unsigned pk[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial receiver on tx_o, sampling mid-bit.
  initial begin
    logic [7:0] b;
    b = '0;
    forever begin
      @(negedge clk);
      if (rst && tx_o === 1'b0) begin
        repeat (BIT/2) @(negedge clk);
        if (tx_o === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            b[i] = tx_o;
          end
          repeat (BIT) @(negedge clk);
          txq.push_back(b);
        end
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    rx_i = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx_i = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  // Reference: parse the packet from its rules and list the bytes that must come back.
  task automatic build_expect(input byte unsigned p[$]);
    int len, plen, n;
    int unsigned r, w;
    exp_q.delete();
    len  = int'(p[2]) + 256 * int'(p[3]);
    plen = (len > 4) ? len - 4 : 0;
    r    = 0;
    if (p[0] == 8'hEC) begin
      for (int i = 0; i < plen; i++) exp_q.push_back(p[4+i]);
    end else if (p[0] == 8'hA0 || p[0] == 8'hA1) begin
      n = plen / 4;
      for (int k = 0; k < n; k++) begin
        w = {p[7+4*k], p[6+4*k], p[5+4*k], p[4+4*k]};
        if (k == 0)             r = w;
        else if (p[0] == 8'hA0) r = r + w;
        else                    r = r * w;
      end
      if (n > 0) begin
        exp_q.push_back(r[7:0]);
        exp_q.push_back(r[15:8]);
        exp_q.push_back(r[23:16]);
        exp_q.push_back(r[31:24]);
      end
    end
  endtask

  task automatic run_pkt(input string tag, input byte unsigned p[$]);
    int t;
    txq.delete();
    build_expect(p);
    foreach (p[i]) send_byte(p[i]);
    t = 0;
    while (txq.size() < exp_q.size() && t < (exp_q.size() + 4) * BYTE_CLKS) begin
      @(negedge clk);
      t++;
    end
    repeat (3 * BYTE_CLKS) @(negedge clk);
    check($sformatf("%s:count", tag), txq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++)
      check($sformatf("%s:b%0d", tag, i), txq[i], exp_q[i]);
    check($sformatf("%s:idle", tag), tx_o, 1);
  endtask

  initial begin
    int t, op_sel, plen;
    byte unsigned op;
    rst  = 1'b0;
    rx_i = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_tx", tx_o, 1);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_tx", tx_o, 1);

    pk = {8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
    run_pkt("echo", pk);
    pk = {8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    run_pkt("add", pk);
    pk = {8'hA0, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00};
    run_pkt("add_wrap", pk);
    pk = {8'hA1, 8'h00, 8'h10, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00,
          8'h02, 8'h00, 8'h00, 8'h00};
    run_pkt("mul", pk);
    pk = {8'h55, 8'h00, 8'h05, 8'h00, 8'h99};
    run_pkt("unknown", pk);
    pk = {8'hA0, 8'h00, 8'h04, 8'h00};
    run_pkt("empty_add", pk);
    pk = {8'hA0, 8'h00, 8'h0A, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_pkt("partial_tail", pk);
    pk = {8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
    run_pkt("echo_after", pk);

    // Reset in the middle of an arithmetic packet.
    pk = {8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01};
    txq.delete();
    foreach (pk[i]) send_byte(pk[i]);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2 * BYTE_CLKS) @(negedge clk);
    check("midpkt_rst:quiet", txq.size(), 0);
    pk = {8'hEC, 8'h00, 8'h05, 8'h00, 8'h33};
    run_pkt("after_rst", pk);

    // Reset while an echoed frame is on the wire aborts it.
    pk = {8'hEC, 8'h00, 8'h05, 8'h00, 8'h00};
    foreach (pk[i]) send_byte(pk[i]);
    t = 0;
    while (tx_o !== 1'b0 && t < 4 * BYTE_CLKS) begin
      @(negedge clk);
      t++;
    end
    check("tx_start_seen", (t < 4 * BYTE_CLKS), 1);
    repeat (2 * BIT) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("tx_abort", tx_o, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3 * BYTE_CLKS) @(negedge clk);
    check("tx_abort_idle", tx_o, 1);

    // Randomized packets.
    for (int n = 0; n < 6; n++) begin
      op_sel = $urandom_range(0, 3);
      case (op_sel)
        0:       op = 8'hEC;
        1:       op = 8'hA0;
        2:       op = 8'hA1;
        default: op = 8'h10 + 8'($urandom_range(0, 15));
      endcase
      pk.delete();
      pk.push_back(op);
      pk.push_back(8'($urandom));
      if ($urandom_range(0, 5) == 0) begin
        pk.push_back(8'($urandom_range(0, 3)));
        pk.push_back(8'h00);
      end else begin
        plen = $urandom_range(1, 10);
        pk.push_back(8'(plen + 4));
        pk.push_back(8'h00);
        for (int i = 0; i < plen; i++) pk.push_back(8'($urandom));
      end
      run_pkt($sformatf("rand%0d_op%02h", n, op), pk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
